mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 39 +++
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch/data request ports and memory-side bus of the arbiter
// slave is the arbiter's view; master is the requesters-plus-memory view.
interface mem_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ready;
   logic [31:0] if_rdata;
   logic        if_err;

   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_ready;
   logic [31:0] d_rdata;
   logic        d_err;

   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   logic        busy;
   logic        grant_id;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
      output if_ready, if_rdata, if_err, d_ready, d_rdata, d_err,
             mem_en, mem_we, mem_addr, mem_wdata, busy, grant_id
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
      input  if_ready, if_rdata, if_err, d_ready, d_rdata, d_err,
             mem_en, mem_we, mem_addr, mem_wdata, busy, grant_id
   );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/data) arbiter onto a single memory port
// Data has priority; fetch is forced through after STARVE_MAX consecutive losses.
module mem_arbiter #(
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 16
) (
   input logic            clk,
   input logic            reset,
   mem_arbiter_if.slave   bus
);

   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
   localparam logic [TW-1:0] TOUT_LIM   = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state, state_next;

   logic [SW-1:0] starve;
   logic [TW-1:0] tcnt;
   logic          err_flag;
   logic          owner;
   logic          mem_en_q;
   logic          mem_we_q;
   logic [31:0]   mem_addr_q;
   logic [31:0]   mem_wdata_q;
   logic [31:0]   if_rdata_q;
   logic [31:0]   d_rdata_q;

   logic          any_req;
   logic          fetch_wins;
   logic          misaligned;
   logic          grant;
   logic          ack_hit;
   logic          timed_out;
   logic [31:0]   sel_addr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      any_req    = bus.if_req | bus.d_req;
      fetch_wins = bus.if_req & (~bus.d_req | (starve == STARVE_LIM));
      sel_addr   = fetch_wins ? bus.if_addr : bus.d_addr;
      misaligned = |sel_addr[1:0];
      grant      = 1'b0;
      ack_hit    = 1'b0;
      timed_out  = 1'b0;
      state_next = state;
      case (state)
         IDLE: begin
            if (any_req) begin
               grant      = 1'b1;
               state_next = misaligned ? RESP : WAIT;
            end
         end
         WAIT: begin
            if (bus.mem_ack) begin
               ack_hit    = 1'b1;
               state_next = RESP;
            end else if (tcnt == TOUT_LIM) begin
               timed_out  = 1'b1;
               state_next = RESP;
            end
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve      <= '0;
         tcnt        <= '0;
         err_flag    <= 1'b0;
         owner       <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
      end else begin
         mem_en_q <= grant & ~misaligned;
         if (grant) begin
            owner       <= ~fetch_wins;
            mem_addr_q  <= {sel_addr[31:2], 2'b00};
            mem_we_q    <= ~fetch_wins & bus.d_we;
            mem_wdata_q <= fetch_wins ? '0 : bus.d_wdata;
            err_flag    <= misaligned;
            tcnt        <= '0;
            // Only a fetch that actually lost counts toward starvation.
            if (fetch_wins) begin
               starve <= '0;
            end else if (bus.if_req && starve != STARVE_LIM) begin
               starve <= starve + 1'b1;
            end
         end
         if (state == WAIT && !ack_hit && !timed_out) begin
            tcnt <= tcnt + 1'b1;
         end
         if (timed_out) begin
            err_flag <= 1'b1;
         end
         // Read data lands as RESP is entered so it is valid alongside ready.
         if (ack_hit && !mem_we_q) begin
            if (owner) begin
               d_rdata_q <= bus.mem_rdata;
            end else begin
               if_rdata_q <= bus.mem_rdata;
            end
         end
      end
   end

   assign bus.if_ready  = (state == RESP) & ~owner;
   assign bus.d_ready   = (state == RESP) & owner;
   assign bus.if_err    = (state == RESP) & ~owner & err_flag;
   assign bus.d_err     = (state == RESP) & owner & err_flag;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.busy      = (state != IDLE);
   assign bus.grant_id  = owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
// Memory either auto-acks in the mem_en cycle or is driven by hand.
module tb_mem_arbiter;

   logic clk;
   logic reset;
   logic auto_ack;
   logic man_ack;
   logic [31:0] man_rdata;
   int checks;
   int errors;

   mem_arbiter_if bus();

   mem_arbiter #(.STARVE_MAX(4), .TIMEOUT(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      return addr ^ 32'hA5A5_0000;
   endfunction

   assign bus.mem_ack   = auto_ack ? bus.mem_en : man_ack;
   assign bus.mem_rdata = auto_ack ? mem_word(bus.mem_addr) : man_rdata;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      reset       = 1'b0;
      auto_ack    = 1'b0;
      man_ack     = 1'b0;
      man_rdata   = '0;
      bus.if_req  = 1'b0;
      bus.if_addr = '0;
      bus.d_req   = 1'b0;
      bus.d_we    = 1'b0;
      bus.d_addr  = '0;
      bus.d_wdata = '0;

      tick();
      tick();
      check("rst_busy",     32'(bus.busy),     0);
      check("rst_if_ready", 32'(bus.if_ready), 0);
      check("rst_d_ready",  32'(bus.d_ready),  0);
      check("rst_mem_en",   32'(bus.mem_en),   0);
      check("rst_mem_addr", bus.mem_addr,      0);
      check("rst_grant_id", 32'(bus.grant_id), 0);
      check("rst_if_rdata", bus.if_rdata,      0);
      reset = 1'b1;
      tick();

      // single fetch with a hand-driven one-cycle ack
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h100;
      tick();
      check("f_mem_en",   32'(bus.mem_en),   1);
      check("f_mem_addr", bus.mem_addr,      32'h100);
      check("f_mem_we",   32'(bus.mem_we),   0);
      check("f_busy",     32'(bus.busy),     1);
      man_ack   = 1'b1;
      man_rdata = 32'hDEAD_BEEF;
      tick();
      man_ack = 1'b0;
      check("f_if_ready", 32'(bus.if_ready), 1);
      check("f_if_rdata", bus.if_rdata,      32'hDEAD_BEEF);
      check("f_if_err",   32'(bus.if_err),   0);
      bus.if_req = 1'b0;
      tick();
      check("f_ready_pulse", 32'(bus.if_ready), 0);
      check("f_idle",        32'(bus.busy),     0);

      // simultaneous store and fetch: store first, then fetch back-to-back
      auto_ack    = 1'b1;
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h200;
      bus.d_req   = 1'b1;
      bus.d_we    = 1'b1;
      bus.d_addr  = 32'h40;
      bus.d_wdata = 32'h1234_5678;
      tick();
      check("s_grant_id",  32'(bus.grant_id), 1);
      check("s_mem_we",    32'(bus.mem_we),   1);
      check("s_mem_wdata", bus.mem_wdata,     32'h1234_5678);
      check("s_mem_addr",  bus.mem_addr,      32'h40);
      tick();
      check("s_d_ready",   32'(bus.d_ready),  1);
      check("s_d_rdata",   bus.d_rdata,       0);
      bus.d_req = 1'b0;
      bus.d_we  = 1'b0;
      tick();
      tick();
      check("s_f_grant",   32'(bus.grant_id), 0);
      check("s_f_mem_en",  32'(bus.mem_en),   1);
      check("s_f_addr",    bus.mem_addr,      32'h200);
      tick();
      check("s_f_ready",   32'(bus.if_ready), 1);
      check("s_f_rdata",   bus.if_rdata,      32'hA5A5_0200);
      bus.if_req = 1'b0;
      tick();

      // data held continuously: fetch must win its fifth arbitration
      bus.d_req   = 1'b1;
      bus.d_we    = 1'b0;
      bus.d_addr  = 32'h80;
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h300;
      for (int i = 1; i <= 5; i++) begin
         tick();
         check($sformatf("stv_gid_%0d", i), 32'(bus.grant_id), (i < 5) ? 32'd1 : 32'd0);
         tick();
         if (i < 5) begin
            check($sformatf("stv_dready_%0d", i), 32'(bus.d_ready), 1);
            check($sformatf("stv_drdata_%0d", i), bus.d_rdata, 32'hA5A5_0080);
         end else begin
            check("stv_ifready", 32'(bus.if_ready), 1);
            check("stv_ifrdata", bus.if_rdata,      32'hA5A5_0300);
            bus.if_req = 1'b0;
            bus.d_req  = 1'b0;
         end
         tick();
      end

      // misaligned load: no memory access, ready and err in the RESP cycle
      bus.d_req  = 1'b1;
      bus.d_addr = 32'h43;
      tick();
      check("mis_mem_en",  32'(bus.mem_en),  0);
      check("mis_d_ready", 32'(bus.d_ready), 1);
      check("mis_d_err",   32'(bus.d_err),   1);
      check("mis_addr",    bus.mem_addr,     32'h40);
      bus.d_req = 1'b0;
      tick();
      check("mis_pulse",   32'(bus.d_ready), 0);
      check("mis_err_off", 32'(bus.d_err),   0);
      check("mis_rdata",   bus.d_rdata,      32'hA5A5_0080);

      // memory never answers: error after 16 WAIT cycles, late ack ignored
      auto_ack   = 1'b0;
      bus.d_req  = 1'b1;
      bus.d_addr = 32'h90;
      tick();
      check("to_mem_en", 32'(bus.mem_en), 1);
      for (int k = 1; k <= 15; k++) tick();
      check("to_early",  32'(bus.d_ready), 0);
      check("to_busy",   32'(bus.busy),    1);
      tick();
      check("to_d_ready", 32'(bus.d_ready), 1);
      check("to_d_err",   32'(bus.d_err),   1);
      man_ack    = 1'b1;
      man_rdata  = 32'hBAD0_BAD0;
      bus.d_req  = 1'b0;
      tick();
      check("to_late_ready", 32'(bus.d_ready), 0);
      check("to_late_busy",  32'(bus.busy),    0);
      check("to_late_rdata", bus.d_rdata,      32'hA5A5_0080);
      tick();
      check("idle_ack_busy",  32'(bus.busy),   0);
      check("idle_ack_mem_en", 32'(bus.mem_en), 0);
      man_ack = 1'b0;

      // reset in WAIT abandons the access; a fresh fetch then completes
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h500;
      tick();
      tick();
      check("rw_busy_pre", 32'(bus.busy), 1);
      reset = 1'b0;
      #1;
      check("rw_busy",     32'(bus.busy),     0);
      check("rw_if_ready", 32'(bus.if_ready), 0);
      check("rw_mem_addr", bus.mem_addr,      0);
      check("rw_d_rdata",  bus.d_rdata,       0);
      bus.if_req = 1'b0;
      tick();
      check("rw_no_ready", 32'(bus.if_ready), 0);
      reset    = 1'b1;
      auto_ack = 1'b1;
      tick();
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h104;
      tick();
      check("pr_mem_en", 32'(bus.mem_en), 1);
      check("pr_addr",   bus.mem_addr,    32'h104);
      bus.if_req = 1'b0;
      tick();
      check("pr_ready",  32'(bus.if_ready), 1);
      check("pr_rdata",  bus.if_rdata,      32'hA5A5_0104);
      check("pr_err",    32'(bus.if_err),   0);
      tick();
      check("pr_done",   32'(bus.if_ready), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
